rf_dump_reader: RTL and testbench

Sequential read-out engine for the 32×32 register file. On a `start` pulse it walks register indices 0..31, drives each index onto the register file's asynchronous read-address port, and captures the returned word. It streams each word out over a valid/ready handshake and reports a running XOR checksum when the sweep completes. It sits beside the register file as a debug/state-dump reader, using one read port while the pipeline is stalled.

---
 rtl/rf_dump_reader_if.sv | 33 +++
 rtl/rf_dump_reader.sv | 115 +++++++++++
 tb/tb_rf_dump_reader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_reader_if.sv
// rtl/rf_dump_reader_if.sv - register-file read port plus outbound beat stream for the dump reader
interface rf_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output rf_addr,
    input  rf_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index,
    output out_last
  );

  modport slave (
    input  rf_addr,
    output rf_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index,
    input  out_last
  );
endinterface

// File: rtl/rf_dump_reader.sv
// rtl/rf_dump_reader.sv - sweeps the register file index by index, streams each word and an XOR checksum
module rf_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  rf_dump_reader_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] index_q;
  logic              last_q;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              capture;
  logic              handshake;

  // out_valid is decoded from state alone, so out_ready never reaches it combinationally.
  assign handshake = (state_q == SEND) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      index_q    <= '0;
      last_q     <= 1'b0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      checksum_q <= checksum_d;
      if (capture) begin
        data_q  <= bus.rf_data;
        index_q <= idx_q;
        last_q  <= (idx_q == LAST_IDX);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    checksum_d = checksum_q;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) begin
          state_d    = FETCH;
          checksum_d = '0;
        end
      end
      FETCH: begin
        capture = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (handshake) begin
          checksum_d = checksum_q ^ data_q;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Abort overrides the handshake: the pending beat is dropped and the partial checksum kept.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      idx_d      = '0;
      checksum_d = checksum_q;
      capture    = 1'b0;
    end
  end

  assign bus.rf_addr   = idx_q;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_index = index_q;
  assign bus.out_last  = (state_q == SEND) && last_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign checksum      = checksum_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb/tb_rf_dump_reader.sv - directed and random-backpressure sweeps of rf_dump_reader against a register-file model
module tb_rf_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  rf_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  rf_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  assign bus.rf_data = rf[bus.rf_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_addr"},   32'(bus.rf_addr),   32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  bus.out_data,       32'd0);
    check({tag, "_out_index"}, 32'(bus.out_index), 32'd0);
    check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
    check({tag, "_checksum"},  checksum,           32'd0);
  endtask

  // mode: 0 ready high, 1 three-cycle stall at sp_idx, 2 stray start at sp_idx,
  //       3 abort at sp_idx, 4 random ready. Called and returns on a falling edge.
  task automatic sweep(input int mode, input int sp_idx, input bit abort_with_start, input int exp_done);
    int          cyc = 0;
    int          exp_idx = 0;
    int          stalls = 0;
    bit          seen_done = 0;
    bit          aborted = 0;
    bit          spur = 0;
    logic [31:0] model = 32'd0;

    start = 1'b1;
    abort = abort_with_start;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    cyc = 1;
    while (1) begin
      if (cyc > 400) begin
        check("sweep_timeout", 32'(cyc), 32'd0);
        break;
      end
      if (aborted) begin
        check("abort_busy",  32'(busy),          32'd0);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_done",  32'(done),          32'd0);
        check("abort_cks",   checksum,           model);
        check("abort_beats", 32'(exp_idx),       32'(sp_idx));
        break;
      end
      if (seen_done) begin
        check("post_done_busy",  32'(busy),          32'd0);
        check("post_done_done",  32'(done),          32'd0);
        check("post_done_valid", 32'(bus.out_valid), 32'd0);
        check("post_done_addr",  32'(bus.rf_addr),   32'd0);
        break;
      end
      bus.out_ready = (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      abort = 1'b0;
      if (bus.out_valid) begin
        check("beat_index", 32'(bus.out_index), 32'(exp_idx));
        check("beat_data",  bus.out_data,       rf[exp_idx]);
        check("beat_last",  32'(bus.out_last),  32'(exp_idx == 31));
        if (mode == 1 && exp_idx == sp_idx && stalls < 3) begin
          bus.out_ready = 1'b0;
          stalls++;
        end
        if (mode == 2 && exp_idx == sp_idx && !spur) begin
          start = 1'b1;
          spur = 1;
        end
        if (mode == 3 && exp_idx == sp_idx) begin
          abort = 1'b1;
          aborted = 1;
        end
        if (bus.out_ready && !abort) begin
          model = model ^ bus.out_data;
          exp_idx++;
        end
      end else if (busy && !done) begin
        check("fetch_addr", 32'(bus.rf_addr), 32'(exp_idx));
      end
      if (done) begin
        seen_done = 1;
        check("done_cks",   checksum,     model);
        check("done_beats", 32'(exp_idx), 32'd32);
        if (exp_done >= 0) check("done_latency", 32'(cyc), 32'(exp_done));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'd1 << i;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);

    // Reset held for two cycles while a beat is pending
    bus.out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("mid_send_reset");
    bus.out_ready = 1'b1;

    sweep(0, 0, 1'b1, 65);
    check("full_cks", checksum, 32'hFFFF_FFFF);
    sweep(1, 5, 1'b0, 68);
    sweep(2, 12, 1'b0, 65);
    sweep(3, 10, 1'b0, -1);
    check("abort_cks_hand", checksum, 32'h0000_03FF);
    @(negedge clk);
    check("abort_cks_hold", checksum, 32'h0000_03FF);
    sweep(0, 0, 1'b0, 65);
    check("restart_cks", checksum, 32'hFFFF_FFFF);

    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      sweep(4, 0, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
